// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the UART instruction-memory loader.
//   loader_state_e : loader FSM states (StCheck only reachable with IMEM_LOADER_CHECKSUM_EN)
//   SYNC_BYTE      : byte that starts (or restarts) a load
//   LEN_BYTES      : bytes in the word-count field
//   WORD_BYTES     : bytes per instruction word
package imem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StWrite,
        StCheck,
        StDone,
        StError
    } loader_state_e;

    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam int unsigned LEN_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver with input synchronizer.
//   clk_max    in  : block clock
//   reset      in  : asynchronous active-high reset
//   rx         in  : serial line, idle high, LSB first
//   byte_valid out : one-cycle pulse, byte_data holds a received byte
//   byte_data  out : last received byte
//   frame_err  out : one-cycle pulse when the stop bit was sampled low
module uart_rx_byte #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk_max,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned BIT_CYC  = CLK_HZ / BAUD;
    localparam int unsigned HALF_CYC = BIT_CYC / 2;
    localparam int unsigned CNT_W    = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

    if (BIT_CYC < 4) begin : g_bit_cyc_check
        $error("uart_rx_byte: CLK_HZ/BAUD must be at least 4");
    end

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rx_meta, rx_sync, rx_prev;

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                cnt_d = '0;
                if (rx_prev && !rx_sync) rx_state_d = RxStart;
            end
            RxStart: begin
                // Mid start bit: a high line here was only a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = rx_sync ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    if (bit_q == 3'd7) rx_state_d = RxStop;
                    else               bit_d      = bit_q + 3'd1;
                end
            end
            RxStop: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d      = '0;
                    rx_state_d = RxIdle;
                    if (rx_sync) valid_d = 1'b1;
                    else         ferr_d  = 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk_max or posedge reset) begin
        if (reset) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state_q <= RxIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: loads a program image received over UART into instruction RAM and holds
// the core in reset until the image is complete.
// Protocol: 0xA5, word count N (16 bit, LE), N little-endian 32-bit words
// [, XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined].
//   clk_max     in  : block clock
//   reset       in  : asynchronous active-high reset
//   rx          in  : UART serial input
//   mem_address out : RAM word address
//   mem_data    out : RAM write data
//   mem_wren    out : one-cycle write pulse per word
//   core_hold   out : reset request to the core
//   busy        out : load in progress
//   load_done   out : last load succeeded
//   load_error  out : last load failed
module imem_uart_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_max,
    input  logic              reset,
    input  logic              rx,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    output logic              core_hold,
    output logic              busy,
    output logic              load_done,
    output logic              load_error
);

    localparam int unsigned LEN_W    = 8 * LEN_BYTES;
    localparam int unsigned CAPACITY = 1 << ADDR_W;

    logic       byte_valid, frame_err;
    logic [7:0] byte_data;

    uart_rx_byte #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk_max    (clk_max),
        .reset      (reset),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    loader_state_e     state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              wren_q, wren_d;
    logic              hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              inc_pend_q, inc_pend_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic             start_load;
    logic [LEN_W-1:0] n_word;
    logic             last_word;
    loader_state_e    end_state;

    assign start_load = byte_valid && (byte_data == SYNC_BYTE);
    assign n_word     = {byte_data, len_q[7:0]};
    assign last_word  = (32'(addr_q) + 32'd1) == 32'(len_q);
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign end_state  = StCheck;
`else
    assign end_state  = StDone;
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wren_d     = 1'b0;
        hold_d     = hold_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        inc_pend_d = inc_pend_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        unique case (state_q)
            StIdle, StDone, StError: begin
                // Status flags follow the state by one cycle.
                if (state_q == StDone) begin
                    hold_d = 1'b0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                if (state_q == StError) begin
                    busy_d = 1'b0;
                    err_d  = 1'b1;
                end
                if (start_load) begin
                    state_d    = StLenLo;
                    hold_d     = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    addr_d     = '0;
                    inc_pend_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            StLenLo: begin
                if (byte_valid) begin
                    len_d[7:0] = byte_data;
                    state_d    = StLenHi;
                end
            end
            StLenHi: begin
                if (byte_valid) begin
                    len_d      = n_word;
                    byte_idx_d = '0;
                    if (32'(n_word) > CAPACITY) state_d = StError;
                    else if (n_word == '0)      state_d = end_state;
                    else                        state_d = StData;
                end
            end
            StData: begin
                if (byte_valid) begin
                    // Address advances on the next word's first byte so it stays put
                    // for the cycle after the write pulse.
                    if (inc_pend_q) begin
                        addr_d     = addr_q + ADDR_W'(1);
                        inc_pend_d = 1'b0;
                    end
                    data_d[{byte_idx_q, 3'b000} +: 8] = byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data;
`endif
                    if (byte_idx_q == 2'(WORD_BYTES - 1)) begin
                        byte_idx_d = '0;
                        wren_d     = 1'b1;
                        state_d    = StWrite;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            StWrite: begin
                if (last_word) begin
                    state_d = end_state;
                end else begin
                    inc_pend_d = 1'b1;
                    state_d    = StData;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            StCheck: begin
                if (byte_valid) state_d = (byte_data == csum_q) ? StDone : StError;
            end
`endif
            default: state_d = StIdle;
        endcase

        if (frame_err && !(state_q inside {StIdle, StDone, StError})) state_d = StError;
    end

    always_ff @(posedge clk_max or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            byte_idx_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wren_q     <= 1'b0;
            hold_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            inc_pend_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wren_q     <= wren_d;
            hold_q     <= hold_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            inc_pend_q <= inc_pend_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign mem_address = addr_q;
    assign mem_data    = data_q;
    assign mem_wren    = wren_q;
    assign core_hold   = hold_q;
    assign busy        = busy_q;
    assign load_done   = done_q;
    assign load_error  = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// tb_imem_uart_loader: directed and randomized loads driven over the UART line; RAM writes
// are captured and compared against the image the bench itself sent.
module tb_imem_uart_loader;

    localparam int unsigned CLK_HZ  = 16_000_000;
    localparam int unsigned BAUD    = 1_000_000;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned BIT_CYC = CLK_HZ / BAUD;
    localparam int unsigned CAP     = 1 << ADDR_W;

    logic              clk_max = 1'b0;
    logic              reset   = 1'b1;
    logic              rx      = 1'b1;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data;
    logic              mem_wren;
    logic              core_hold, busy, load_done, load_error;

    imem_uart_loader #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_max     (clk_max),
        .reset       (reset),
        .rx          (rx),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .core_hold   (core_hold),
        .busy        (busy),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    always #5 clk_max = ~clk_max;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Write capture: {address, data} per mem_wren cycle, plus protocol sanity counters.
    logic [ADDR_W+31:0] wr_q[$];
    int unsigned        hold_bad = 0;
    int unsigned        unstable = 0;
    logic               prev_wren = 1'b0;
    logic [ADDR_W-1:0]  w_addr;
    logic [31:0]        w_data;

    always @(negedge clk_max) begin
        if (reset) begin
            prev_wren <= 1'b0;
        end else begin
            if (prev_wren && (mem_address !== w_addr || mem_data !== w_data || mem_wren !== 1'b0))
                unstable <= unstable + 1;
            if (mem_wren === 1'b1) begin
                wr_q.push_back({mem_address, mem_data});
                if (core_hold !== 1'b1) hold_bad <= hold_bad + 1;
            end
            w_addr    <= mem_address;
            w_data    <= mem_data;
            prev_wren <= (mem_wren === 1'b1);
        end
    end

    // Image the reference model expects to see written (address i gets exp_words[i]).
    logic [31:0] exp_words[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT_CYC) @(posedge clk_max);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CYC) @(posedge clk_max);
        end
        rx = stop_bit;
        repeat (BIT_CYC) @(posedge clk_max);
        rx = 1'b1;
        repeat (BIT_CYC) @(posedge clk_max);
    endtask

    task automatic wait_settled(input string tag);
        int n = 0;
        while ((busy || !(load_done || load_error)) && n < 4000) begin
            @(posedge clk_max);
            n++;
        end
        repeat (4) @(posedge clk_max);
        chk({tag, "_timeout"}, 64'(n >= 4000), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_addr"}, 64'(mem_address), 64'd0);
        chk({tag, "_data"}, 64'(mem_data), 64'd0);
        chk({tag, "_wren"}, 64'(mem_wren), 64'd0);
        chk({tag, "_hold"}, 64'(core_hold), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(load_done), 64'd0);
        chk({tag, "_err"}, 64'(load_error), 64'd0);
    endtask

    // Sends a complete load of exp_words with count field n and checks the outcome.
    // corrupt flips the checksum byte (checksum builds only).
    task automatic load_and_check(input string tag, input logic [15:0] n, input bit corrupt);
        logic [7:0]  x;
        logic [31:0] w;
        bit          in_range;
        bit          ok;
        x = 8'h00;
        wr_q.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(n[7:0], 1'b1);
        send_byte(n[15:8], 1'b1);
        for (int i = 0; i < exp_words.size(); i++) begin
            w = exp_words[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], 1'b1);
                x = x ^ w[8*k +: 8];
            end
        end
        in_range = (32'(n) <= CAP);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (in_range) send_byte(corrupt ? (x ^ 8'h01) : x, 1'b1);
        ok = in_range && !corrupt;
`else
        ok = in_range && !corrupt;
`endif
        wait_settled(tag);
        chk({tag, "_nwr"}, 64'(wr_q.size()), in_range ? 64'(exp_words.size()) : 64'd0);
        if (in_range) begin
            for (int i = 0; i < exp_words.size() && i < wr_q.size(); i++) begin
                chk({tag, "_wa"}, 64'(wr_q[i][ADDR_W+31:32]), 64'(i));
                chk({tag, "_wd"}, 64'(wr_q[i][31:0]), 64'(exp_words[i]));
            end
        end
        chk({tag, "_done"}, 64'(load_done), 64'(ok));
        chk({tag, "_err"}, 64'(load_error), 64'(!ok));
        chk({tag, "_hold"}, 64'(core_hold), 64'(!ok));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [15:0] n;
        logic [7:0]  g;

        // Reset state.
        repeat (5) @(posedge clk_max);
        @(negedge clk_max);
        check_reset_values("rst");
        reset = 1'b0;
        repeat (4) @(posedge clk_max);

        // Two-word image.
        exp_words = '{32'h12345678, 32'hDEADBEEF};
        load_and_check("two_word", 16'd2, 1'b0);

        // Garbage while done is ignored, then an empty image.
        wr_q.delete();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        chk("garbage_nwr", 64'(wr_q.size()), 64'd0);
        chk("garbage_done", 64'(load_done), 64'd1);
        exp_words.delete();
        load_and_check("empty", 16'd0, 1'b0);

        // Oversize count.
        exp_words.delete();
        load_and_check("oversize", 16'd1025, 1'b0);

        // Bad stop bit in the middle of a word.
        wr_q.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h5A, 1'b0);
        wait_settled("ferr");
        chk("ferr_nwr", 64'(wr_q.size()), 64'd0);
        chk("ferr_err", 64'(load_error), 64'd1);
        chk("ferr_done", 64'(load_done), 64'd0);
        chk("ferr_hold", 64'(core_hold), 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_words = '{32'h08040201};
        load_and_check("csum_ok", 16'd1, 1'b0);
        load_and_check("csum_bad", 16'd1, 1'b1);
`endif

        // Randomized images with random leading garbage.
        for (int it = 0; it < 4; it++) begin
            for (int j = 0; j < int'($urandom_range(1, 2)); j++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'hA4;
                send_byte(g, 1'b1);
            end
            n = 16'($urandom_range(1, 4));
            exp_words.delete();
            for (int i = 0; i < int'(n); i++) exp_words.push_back($urandom);
            load_and_check("rand", n, 1'b0);
        end
        exp_words.delete();
        n = 16'(CAP + 1 + $urandom_range(0, 2000));
        load_and_check("rand_oversize", n, 1'b0);

        // Good load, then reset part-way through the next one.
        exp_words = '{32'hCAFEF00D};
        load_and_check("pre_reset", 16'd1, 1'b0);
        wr_q.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int k = 0; k < 5; k++) send_byte(8'(8'h30 + k), 1'b1);
        chk("mid_nwr", 64'(wr_q.size()), 64'd1);
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_hold", 64'(core_hold), 64'd1);
        #3 reset = 1'b1;
        #1 check_reset_values("mid_rst");
        repeat (3) @(posedge clk_max);
        #2 reset = 1'b0;
        @(posedge clk_max);
        exp_words = '{32'h0BADC0DE, 32'h00000013};
        load_and_check("post_reset", 16'd2, 1'b0);

        chk("wren_stable", 64'(unstable), 64'd0);
        chk("hold_during_wr", 64'(hold_bad), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
